// File: rtl/micro_timer_scheduler_pkg.sv
// Shared definitions for the micro timer scheduler: register map, CTRL/STATUS bit positions, scan FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package micro_timer_sched_pkg;

  // Global register offsets (address[5] = 0)
  localparam logic [1:0] G_PRESCALE = 2'd0;
  localparam logic [1:0] G_PENDING  = 2'd1;
  localparam logic [1:0] G_IRQ_ID   = 2'd2;
  localparam logic [1:0] G_STATUS   = 2'd3;

  // Channel register offsets (address[5] = 1, address[4:2] = channel)
  localparam logic [1:0] C_CTRL   = 2'd0;
  localparam logic [1:0] C_COUNT  = 2'd1;
  localparam logic [1:0] C_RELOAD = 2'd2;

  // CTRL bits
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_RELOAD = 2;

  // STATUS bits
  localparam int ST_RUN     = 0;
  localparam int ST_OVERRUN = 1;

  // IRQ_ID: valid flag position; channel index sits in the low bits
  localparam int IRQ_ID_VALID = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sched_state_t;

endpackage

// File: rtl/micro_timer_scheduler_prio_enc.sv
// Lowest-index priority encoder: reports the lowest set request bit and whether any bit is set.
// Latency: combinational.
// Backpressure: none.
// Ports: req (N request bits) -> valid (any set), idx (lowest set bit index).
module micro_prio_enc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Walk downwards so the lowest set bit is the last assignment to win.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/micro_timer_scheduler.sv
// NCHAN virtual timer channels sharing one prescaler and one decrementer; a scan FSM services each channel once per tick.
// Latency: writes take effect on the next edge; reads return after exactly one stall cycle; irq lags pending by one cycle.
// Backpressure: reads assert waitrequest for their first cycle only; writes never stall.
// Ports: clock, clock_sreset (async, active-high); address/writedata/read/write bus in;
//        readdata/waitrequest bus out; irq = registered OR of (pending & irq_en).
module micro_timer_scheduler #(
  parameter int WIDTHD = 32,
  parameter int NCHAN  = 8,
  parameter int WIDTHP = 16
) (
  input  logic              clock,
  input  logic              clock_sreset,
  input  logic [5:0]        address,
  input  logic [WIDTHD-1:0] writedata,
  output logic [WIDTHD-1:0] readdata,
  input  logic              read,
  input  logic              write,
  output logic              waitrequest,
  output logic              irq
);
  import micro_timer_sched_pkg::*;

  localparam int WIDTHT = (WIDTHD < 32) ? WIDTHD : 32;
  localparam int CW     = $clog2(NCHAN);

  logic [WIDTHP-1:0] prescale, presc;
  logic              run, overrun, tick;
  logic [NCHAN-1:0]  pending, en, irq_en, rld;
  logic [WIDTHT-1:0] count      [NCHAN];
  logic [WIDTHT-1:0] reload_val [NCHAN];

  sched_state_t state, state_nxt;
  logic [CW-1:0] ch, ch_nxt;
  logic          ovr_set;

  logic              rd_lat;
  logic [WIDTHD-1:0] rd_mux;

  // Bus decode
  logic          is_chan, chan_ok, wr_glob, wr_chan;
  logic [1:0]    reg_sel;
  logic [CW-1:0] a_ch;

  assign is_chan = address[5];
  assign reg_sel = address[1:0];
  assign a_ch    = address[CW+1:2];
  assign chan_ok = is_chan && (int'(address[4:2]) < NCHAN);
  assign wr_glob = write && !is_chan;
  assign wr_chan = write && chan_ok;

  // Prescaler: tick when the running count reaches zero, so the tick period is PRESCALE+1 cycles.
  assign tick = run && (presc == '0);

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      presc <= '0;
    end else if (!run || tick) begin
      presc <= prescale;
    end else begin
      presc <= presc - WIDTHP'(1);
    end
  end

  // Scan FSM
  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      state <= IDLE;
      ch    <= '0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = SCAN;
          ch_nxt    = '0;
        end
      end
      SCAN: begin
        // A tick mid-sweep is lost; flag it rather than restarting the sweep.
        ovr_set = tick;
        if (ch == CW'(NCHAN - 1)) state_nxt = IDLE;
        else                      ch_nxt    = ch + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared decrementer: service of the channel under the scan pointer
  logic              svc;
  logic [WIDTHT-1:0] cur;
  logic [NCHAN-1:0]  pend_set, pend_clr;

  assign svc = (state == SCAN) && en[ch];
  assign cur = count[ch];

  always_comb begin
    pend_set = '0;
    if (svc && (cur == WIDTHT'(1))) pend_set[ch] = 1'b1;
  end

  assign pend_clr = (wr_glob && reg_sel == G_PENDING) ? writedata[NCHAN-1:0] : '0;

  // Priority encoder for IRQ_ID
  logic          prio_vld;
  logic [CW-1:0] prio_idx;

  micro_prio_enc #(.N(NCHAN), .IW(CW)) u_prio (
    .req   (pending & irq_en),
    .valid (prio_vld),
    .idx   (prio_idx)
  );

  // Register file and channel state
  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      prescale <= '0;
      run      <= 1'b0;
      overrun  <= 1'b0;
      pending  <= '0;
      en       <= '0;
      irq_en   <= '0;
      rld      <= '0;
      irq      <= 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
        count[i]      <= '0;
        reload_val[i] <= '0;
      end
    end else begin
      // Set wins over a same-cycle W1C.
      pending <= (pending & ~pend_clr) | pend_set;
      irq     <= |(pending & irq_en);

      if (ovr_set)
        overrun <= 1'b1;
      else if (wr_glob && reg_sel == G_STATUS && writedata[ST_OVERRUN])
        overrun <= 1'b0;

      if (wr_glob) begin
        case (reg_sel)
          G_PRESCALE: prescale <= writedata[WIDTHP-1:0];
          G_STATUS:   run      <= writedata[ST_RUN];
          default:    ;
        endcase
      end

      if (svc) begin
        if (cur > WIDTHT'(1))       count[ch] <= cur - WIDTHT'(1);
        else if (cur == WIDTHT'(1)) count[ch] <= '0;
        else if (rld[ch])           count[ch] <= reload_val[ch];
        else                        en[ch]    <= 1'b0;   // one-shot finished
      end

      // Placed after the service update so a bus write to the same channel wins.
      if (wr_chan) begin
        case (reg_sel)
          C_CTRL: begin
            en[a_ch]     <= writedata[CTRL_EN];
            irq_en[a_ch] <= writedata[CTRL_IRQ_EN];
            rld[a_ch]    <= writedata[CTRL_RELOAD];
          end
          C_COUNT:  count[a_ch]      <= writedata[WIDTHT-1:0];
          C_RELOAD: reload_val[a_ch] <= writedata[WIDTHT-1:0];
          default:  ;
        endcase
      end
    end
  end

  // Read path
  always_comb begin
    rd_mux = '0;
    if (!is_chan) begin
      case (reg_sel)
        G_PRESCALE: rd_mux[WIDTHP-1:0] = prescale;
        G_PENDING:  rd_mux[NCHAN-1:0]  = pending;
        G_IRQ_ID: begin
          rd_mux[IRQ_ID_VALID] = prio_vld;
          rd_mux[CW-1:0]       = prio_idx;
        end
        default: begin
          rd_mux[ST_RUN]     = run;
          rd_mux[ST_OVERRUN] = overrun;
        end
      endcase
    end else if (chan_ok) begin
      case (reg_sel)
        C_CTRL: begin
          rd_mux[CTRL_EN]     = en[a_ch];
          rd_mux[CTRL_IRQ_EN] = irq_en[a_ch];
          rd_mux[CTRL_RELOAD] = rld[a_ch];
        end
        C_COUNT:  rd_mux[WIDTHT-1:0] = count[a_ch];
        C_RELOAD: rd_mux[WIDTHT-1:0] = reload_val[a_ch];
        default:  ;
      endcase
    end
  end

  // One stall cycle per read: capture during the stalled cycle, present on the next.
  assign waitrequest = read && !rd_lat;

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      rd_lat   <= 1'b0;
      readdata <= '0;
    end else begin
      rd_lat <= rd_lat ? 1'b0 : read;
      if (read && !rd_lat) readdata <= rd_mux;
    end
  end

endmodule
